fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode and controlled by the hazard unit's pc_enab, enab_FD and flush signals. It owns the PC register, the instruction-memory request/response handshake, the branch/jump redirect, and the F/D pipeline register that feeds decode. It tolerates variable-latency instruction memory, buffers a returned word while the pipeline is stalled, and discards wrong-path responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous reset, active-low
pc_enab  input  1  hazard unit: PC may advance; redirects accepted only when 1
enab_FD  input  1  hazard unit: F/D register may load
flush_FD  input  1  load a bubble into F/D (taken branch/jump squash)
pc_src_D  input  1  decode: branch taken
pc_branch_D  input  32  branch target
jump_D  input  1  decode: jump
pc_jump_D  input  32  jump target
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, equal to pc_F
imem_ready  input  1  response valid this cycle; zero-wait allowed
imem_rdata  input  32  instruction word, valid when imem_ready=1
instr_D  output  32  F/D instruction
pc_plus4_D  output  32  F/D PC+4
valid_D  output  1  F/D holds a real instruction; 0 means bubble
imem_stall  output  1  fetch waiting on memory; informational only, must not feed pc_enab

Behaviour:
- Reset, while reset_n=0 at the edge:
  - state=REQ, pc_F=RESET_PC, redirect_pc=0, hold buffer=0.
  - instr_D=0, pc_plus4_D=0, valid_D=0.
  - imem_req is 0 while reset_n=0.
- Reset mid-request abandons the outstanding fetch; any imem_ready arriving during reset is ignored.
- Request protocol: imem_req and imem_addr stay stable from assertion until the cycle imem_ready=1. Exactly one response per request.
- Redirect:
  - redirect = pc_enab & (jump_D | pc_src_D).
  - Target = pc_jump_D when jump_D=1 (jump wins if both are set), else pc_branch_D.
- fetch_ready = (state==REQ & imem_ready) | state==HOLD. The fetched word is imem_rdata in REQ and the hold buffer in HOLD.
- PC arithmetic: pc_F+4 is 32-bit modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- State REQ: imem_req=1, imem_stall=~imem_ready.
  - imem_ready & pc_enab: pc_F <= redirect ? target : pc_F+4; stay in REQ. The next request issues the following cycle.
  - imem_ready & ~pc_enab: capture imem_rdata into the hold buffer; go to HOLD.
  - ~imem_ready & redirect: redirect_pc <= target; go to DRAIN (the pending response is wrong-path).
  - ~imem_ready & ~redirect: wait.
- State HOLD: imem_req=0, imem_stall=0.
  - pc_enab=1: pc_F <= redirect ? target : pc_F+4; go to REQ.
  - pc_enab=0: stay; the buffer is held.
- State DRAIN: imem_req=1 at the old pc_F, imem_stall=1.
  - A further redirect overwrites redirect_pc (latest wins).
  - When imem_ready=1: discard imem_rdata; pc_F <= redirect_pc, or the new target if redirect is asserted that same cycle; go to REQ.
- F/D register updates only when enab_FD=1:
  - flush_FD=1 or no fetched word available: instr_D=0, pc_plus4_D=0, valid_D=0.
  - Otherwise: instr_D=fetched word, pc_plus4_D=pc_F+4, valid_D=1.
  - DRAIN never supplies a word.
  - enab_FD=0: F/D holds its value, and flush_FD is ignored.
- Latency: with zero-wait memory and no stalls, the word at address A appears in instr_D one cycle after imem_addr=A, giving one instruction per cycle.

Test Plan:
- Reset release with RESET_PC=0, zero-wait memory returning addr+100, no stalls -> imem_addr 0,4,8; instr_D 100,104,108 on consecutive cycles; pc_plus4_D 4,8,12.
- 3-cycle memory latency -> imem_req held at addr 0 for 3 cycles with imem_stall=1 and valid_D=0, then instr_D=100 and valid_D=1 for one cycle.
- Response arrives while pc_enab=0 and enab_FD=0 for 2 cycles -> HOLD entered, imem_req=0, F/D unchanged; when enables rise, the buffered word loads and imem_addr advances by 4.
- Zero-wait memory, at imem_addr=0x20, assert pc_src_D=1, pc_branch_D=0x100, flush_FD=1 -> next imem_addr=0x100, valid_D=0 for one cycle, then instr_D=mem[0x100].
- Redirect to 0x200 during a pending 4-cycle fetch of 0x40 -> 0x40 response discarded (never reaches valid_D=1), next request at 0x200; a second redirect to 0x300 before the response -> request at 0x300.
- jump_D and pc_src_D asserted together (0x400, 0x500) -> 0x400; pc_F=0xFFFF_FFFC with zero-wait memory -> next imem_addr=0; reset_n low mid-DRAIN -> imem_req=0 and valid_D=0 next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
// -----------------------------------------------------------------------------
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, the
// instruction-memory request/response handshake, branch/jump redirects and
// the F/D pipeline register feeding decode. Tolerates variable-latency memory,
// buffers a returned word while the pipeline is stalled, and discards the
// wrong-path response that is still in flight when a redirect arrives.
//
// Ports:
//   clk, reset_n           clock; synchronous active-low reset
//   pc_enab                hazard unit: PC may advance / redirect accepted
//   enab_FD, flush_FD      hazard unit: F/D load enable, bubble insertion
//   pc_src_D, pc_branch_D  decode: branch taken and its target
//   jump_D, pc_jump_D      decode: jump and its target (wins over branch)
//   imem_req, imem_addr    fetch request and address (address == pc_F)
//   imem_ready, imem_rdata memory response strobe and instruction word
//   instr_D, pc_plus4_D    F/D register contents
//   valid_D                F/D holds a real instruction (0 = bubble)
//   imem_stall             fetch is waiting on memory (informational)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_enab,
  input  logic        enab_FD,
  input  logic        flush_FD,
  input  logic        pc_src_D,
  input  logic [31:0] pc_branch_D,
  input  logic        jump_D,
  input  logic [31:0] pc_jump_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D,
  output logic        imem_stall
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_F;
  logic [31:0] redirect_pc;
  logic [31:0] hold_buf;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4_F;
  logic [31:0] pc_next_seq;
  logic        fetch_ready;
  logic [31:0] fetch_word;

  assign redirect    = pc_enab & (jump_D | pc_src_D);
  assign target      = jump_D ? pc_jump_D : pc_branch_D;
  assign pc_plus4_F  = pc_F + 32'd4;
  assign pc_next_seq = redirect ? target : pc_plus4_F;

  // A word is available either straight off the bus or from the hold buffer;
  // a DRAIN response is wrong-path and never counts.
  assign fetch_ready = ((state == ST_REQ) & imem_ready) | (state == ST_HOLD);
  assign fetch_word  = (state == ST_HOLD) ? hold_buf : imem_rdata;

  assign imem_addr = pc_F;

  always_comb begin
    imem_req   = 1'b0;
    imem_stall = 1'b0;
    if (reset_n) begin
      case (state)
        ST_REQ: begin
          imem_req   = 1'b1;
          imem_stall = ~imem_ready;
        end
        ST_DRAIN: begin
          imem_req   = 1'b1;
          imem_stall = 1'b1;
        end
        default: begin
          imem_req   = 1'b0;
          imem_stall = 1'b0;
        end
      endcase
    end
  end

  // Fetch control: PC, request state, redirect target, hold buffer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_REQ;
      pc_F        <= RESET_PC;
      redirect_pc <= 32'd0;
      hold_buf    <= 32'd0;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_ready) begin
            if (pc_enab) begin
              pc_F <= pc_next_seq;
            end else begin
              hold_buf <= imem_rdata;
              state    <= ST_HOLD;
            end
          end else if (redirect) begin
            // Request must stay stable until answered, so remember the target
            // and throw away the response when it comes.
            redirect_pc <= target;
            state       <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (pc_enab) begin
            pc_F  <= pc_next_seq;
            state <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_ready) begin
            pc_F  <= redirect ? target : redirect_pc;
            state <= ST_REQ;
          end else if (redirect) begin
            redirect_pc <= target;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  // F/D pipeline register boundary
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_D    <= 32'd0;
      pc_plus4_D <= 32'd0;
      valid_D    <= 1'b0;
    end else if (enab_FD) begin
      if (flush_FD || !fetch_ready) begin
        instr_D    <= 32'd0;
        pc_plus4_D <= 32'd0;
        valid_D    <= 1'b0;
      end else begin
        instr_D    <= fetch_word;
        pc_plus4_D <= pc_plus4_F;
        valid_D    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_enab, enab_FD, flush_FD, pc_src_D, jump_D;
  logic [31:0] pc_branch_D, pc_jump_D;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_D, pc_plus4_D;
  logic        valid_D, imem_stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .pc_enab(pc_enab), .enab_FD(enab_FD),
    .flush_FD(flush_FD), .pc_src_D(pc_src_D), .pc_branch_D(pc_branch_D),
    .jump_D(jump_D), .pc_jump_D(pc_jump_D), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_D(instr_D), .pc_plus4_D(pc_plus4_D), .valid_D(valid_D),
    .imem_stall(imem_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          pe, fe, fl, src, jmp, rdy;
    logic [31:0] br, jt, rd;
    bit          ereq, estall, evalid;
    logic [31:0] eaddr, einstr, epc4;
  } vec_t;

  function automatic vec_t mk(bit pe, bit fe, bit fl, bit src, logic [31:0] br,
                              bit jmp, logic [31:0] jt, bit rdy, logic [31:0] rd,
                              bit ereq, logic [31:0] eaddr, bit estall,
                              logic [31:0] einstr, logic [31:0] epc4, bit evalid);
    vec_t v;
    v.pe = pe; v.fe = fe; v.fl = fl; v.src = src; v.br = br; v.jmp = jmp;
    v.jt = jt; v.rdy = rdy; v.rd = rd; v.ereq = ereq; v.eaddr = eaddr;
    v.estall = estall; v.einstr = einstr; v.epc4 = epc4; v.evalid = evalid;
    return v;
  endfunction

  task automatic drive(input bit pe, input bit fe, input bit fl, input bit src,
                       input logic [31:0] br, input bit jmp, input logic [31:0] jt,
                       input bit rdy, input logic [31:0] rd);
    pc_enab = pe; enab_FD = fe; flush_FD = fl; pc_src_D = src; pc_branch_D = br;
    jump_D = jmp; pc_jump_D = jt; imem_ready = rdy; imem_rdata = rd;
  endtask

  // Reference model state: what the fetch unit is doing, in plain terms.
  logic [31:0] m_pc, m_buf, m_tgt, m_instr, m_pc4;
  bit          m_have_word, m_wrong, m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_buf = 0; m_tgt = 0; m_have_word = 0; m_wrong = 0;
    m_instr = 0; m_pc4 = 0; m_valid = 0;
  endtask

  task automatic model_step();
    bit          redir, avail;
    logic [31:0] tgt, word;
    if (!reset_n) begin
      model_reset();
      return;
    end
    redir = pc_enab && (jump_D || pc_src_D);
    tgt   = jump_D ? pc_jump_D : pc_branch_D;
    avail = m_have_word || (!m_wrong && imem_ready);
    word  = m_have_word ? m_buf : imem_rdata;
    if (enab_FD) begin
      if (flush_FD || !avail) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else begin
        m_instr = word; m_pc4 = m_pc + 4; m_valid = 1;
      end
    end
    if (m_wrong) begin
      if (imem_ready) begin
        m_pc = redir ? tgt : m_tgt;
        m_wrong = 0;
      end else if (redir) m_tgt = tgt;
    end else if (m_have_word) begin
      if (pc_enab) begin
        m_pc = redir ? tgt : m_pc + 4;
        m_have_word = 0;
      end
    end else if (imem_ready) begin
      if (pc_enab) m_pc = redir ? tgt : m_pc + 4;
      else begin
        m_have_word = 1;
        m_buf = imem_rdata;
      end
    end else if (redir) begin
      m_wrong = 1;
      m_tgt = tgt;
    end
  endtask

  vec_t tbl[22];
  localparam logic [31:0] BAD = 32'hBAD0_0000;

  initial begin
    //           pe fe fl src br      jmp jt           rdy rd           req addr         st  instr        pc4          v
    tbl[0]  = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'd100,      1, 32'h0,        0, 32'd100,     32'd4,       1);
    tbl[1]  = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'd104,      1, 32'h4,        0, 32'd104,     32'd8,       1);
    tbl[2]  = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'd108,      1, 32'h8,        0, 32'd108,     32'd12,      1);
    tbl[3]  = mk(1, 1, 0, 0, 0,       0, 0,            0, BAD,          1, 32'hC,        1, 32'd0,       32'd0,       0);
    tbl[4]  = mk(1, 1, 0, 0, 0,       0, 0,            0, BAD,          1, 32'hC,        1, 32'd0,       32'd0,       0);
    tbl[5]  = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'd112,      1, 32'hC,        0, 32'd112,     32'd16,      1);
    tbl[6]  = mk(0, 0, 0, 0, 0,       0, 0,            1, 32'd116,      1, 32'h10,       0, 32'd112,     32'd16,      1);
    tbl[7]  = mk(0, 0, 0, 0, 0,       0, 0,            0, BAD,          0, 32'h10,       0, 32'd112,     32'd16,      1);
    tbl[8]  = mk(0, 0, 0, 0, 0,       0, 0,            0, BAD,          0, 32'h10,       0, 32'd112,     32'd16,      1);
    tbl[9]  = mk(1, 1, 0, 0, 0,       0, 0,            0, BAD,          0, 32'h10,       0, 32'd116,     32'd20,      1);
    tbl[10] = mk(1, 1, 1, 1, 32'h100, 0, 0,            1, 32'd120,      1, 32'h14,       0, 32'd0,       32'd0,       0);
    tbl[11] = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'h164,      1, 32'h100,      0, 32'h164,     32'h104,     1);
    tbl[12] = mk(1, 1, 1, 1, 32'h200, 0, 0,            0, BAD,          1, 32'h104,      1, 32'd0,       32'd0,       0);
    tbl[13] = mk(1, 1, 1, 1, 32'h300, 0, 0,            0, BAD,          1, 32'h104,      1, 32'd0,       32'd0,       0);
    tbl[14] = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'hDEAD,     1, 32'h104,      1, 32'd0,       32'd0,       0);
    tbl[15] = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'h364,      1, 32'h300,      0, 32'h364,     32'h304,     1);
    tbl[16] = mk(1, 1, 1, 1, 32'h500, 1, 32'h400,      1, 32'h368,      1, 32'h304,      0, 32'd0,       32'd0,       0);
    tbl[17] = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'h464,      1, 32'h400,      0, 32'h464,     32'h404,     1);
    tbl[18] = mk(1, 1, 0, 0, 0,       1, 32'hFFFFFFFC, 1, 32'h468,      1, 32'h404,      0, 32'h468,     32'h408,     1);
    tbl[19] = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'h60,       1, 32'hFFFFFFFC, 0, 32'h60,      32'h0,       1);
    tbl[20] = mk(1, 1, 0, 0, 0,       0, 0,            1, 32'd100,      1, 32'h0,        0, 32'd100,     32'd4,       1);
    tbl[21] = mk(0, 0, 1, 0, 0,       0, 0,            0, BAD,          1, 32'h4,        1, 32'd100,     32'd4,       1);

    // Reset state
    reset_n = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h1234);
    @(posedge clk); @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr_D, 32'd0);
    chk("rst_pc4", pc_plus4_D, 32'd0);
    chk("rst_valid", {31'd0, valid_D}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].pe, tbl[i].fe, tbl[i].fl, tbl[i].src, tbl[i].br,
            tbl[i].jmp, tbl[i].jt, tbl[i].rdy, tbl[i].rd);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].ereq});
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("v%0d_stall", i), {31'd0, imem_stall}, {31'd0, tbl[i].estall});
      @(posedge clk); #1;
      chk($sformatf("v%0d_instr", i), instr_D, tbl[i].einstr);
      chk($sformatf("v%0d_pc4", i), pc_plus4_D, tbl[i].epc4);
      chk($sformatf("v%0d_valid", i), {31'd0, valid_D}, {31'd0, tbl[i].evalid});
    end

    // Reset in the middle of a DRAIN: pc_F=4, request pending, redirect to 0x700
    @(negedge clk);
    drive(1, 1, 1, 1, 32'h700, 0, 0, 0, BAD);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0, 0, BAD);
    #1;
    chk("drain_stall", {31'd0, imem_stall}, 32'd1);
    chk("drain_addr", imem_addr, 32'h4);
    @(negedge clk);
    reset_n = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0, 1, 32'h704);
    #1;
    chk("drain_rst_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("drain_rst_valid", {31'd0, valid_D}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 0, 0, BAD);
    #1;
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 32'd100);
    @(posedge clk); #1;
    chk("restart_instr", instr_D, 32'd100);
    chk("restart_valid", {31'd0, valid_D}, 32'd1);

    // Randomized run against the reference model
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      bit          rdy, srcb, jmpb, pe;
      logic [31:0] br, jt;
      @(negedge clk);
      reset_n = ($urandom_range(0, 99) != 0);
      pe   = ($urandom_range(0, 3) != 0);
      srcb = ($urandom_range(0, 5) == 0);
      jmpb = ($urandom_range(0, 7) == 0);
      br   = {$urandom_range(0, 255), 2'b00};
      jt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 255), 2'b00};
      if (!reset_n) rdy = $urandom_range(0, 1);
      else          rdy = !m_have_word && ($urandom_range(0, 2) == 0);
      drive(pe, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), srcb, br,
            jmpb, jt, rdy, rdy ? (m_pc + 32'd100) : $urandom);
      #1;
      if (!reset_n) chk("rnd_rst_req", {31'd0, imem_req}, 32'd0);
      else begin
        chk("rnd_req", {31'd0, imem_req}, {31'd0, !m_have_word});
        chk("rnd_addr", imem_addr, m_pc);
        chk("rnd_stall", {31'd0, imem_stall},
            {31'd0, m_wrong || (!m_have_word && !imem_ready)});
      end
      model_step();
      @(posedge clk); #1;
      chk("rnd_instr", instr_D, m_instr);
      chk("rnd_pc4", pc_plus4_D, m_pc4);
      chk("rnd_valid", {31'd0, valid_D}, {31'd0, m_valid});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
